// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte FIFO feeding an 8N1 UART transmitter with a registered serial line
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d, wr, pop, bit_end;
  assign o_ready      = count_q < FULL;
  assign wr           = i_valid && o_ready;
  assign bit_end      = baud_q == BAUD_MAX;
  assign count_d      = count_q + CW'(wr) - CW'(pop);
  assign o_tx         = tx_q;
  assign o_busy       = state_q != IDLE || count_q != '0;
  assign o_fifo_count = count_q;
  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge i_clk) begin
    if (wr && !i_reset) mem_q[wr_ptr_q] <= i_data;
  end
  // state, pointers, baud timing and the registered serial output
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_q + AW'(wr);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end
  // next-state logic; tx_d is the line value for the cycle after this edge, and a pop restarts a frame
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        pop    = count_q != '0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
        tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
      end
      default: if (bit_end) begin
        state_d = IDLE;
        tx_d    = 1'b1;
        pop     = count_q != '0;
      end
    endcase
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      baud_d  = '0;
      state_d = START;
      tx_d    = 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed and random checks of the UART transmit serializer
module tb_uart_tx_serializer;
  logic       i_clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, o_ready, o_tx, o_busy;
  logic [7:0] i_data = 8'h00;
  logic [3:0] o_fifo_count;
  int         errors = 0, checks = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_fifo_count(o_fifo_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // expected line level k cycles after the pop edge of a frame carrying b (4 cycles per bit)
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int j = k / 4;
    return j == 0 ? 1'b0 : j == 9 ? 1'b1 : b[j-1];
  endfunction

  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b1; i_data = 8'hFF;
    tick(); tick();
    checks++; if (o_fifo_count !== 4'd0) begin errors++; $display("FAIL reset_write_ignored got %0d exp 0", o_fifo_count); end
    i_reset = 1'b0; i_valid = 1'b0;
    tick();
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", o_tx); end
    checks++; if (o_fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", o_fifo_count); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
  endtask

  task automatic test_single();
    i_valid = 1'b1; i_data = 8'h55;
    tick();
    i_valid = 1'b0;
    checks++; if (o_fifo_count !== 4'd1) begin errors++; $display("FAIL single_count_after_write got %0d exp 1", o_fifo_count); end
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL single_tx_before_pop got %b exp 1", o_tx); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy_queued got %b exp 1", o_busy); end
    tick();
    checks++; if (o_fifo_count !== 4'd0) begin errors++; $display("FAIL single_count_after_pop got %0d exp 0", o_fifo_count); end
    for (int k = 0; k < 40; k++) begin
      checks++; if (o_tx !== exp_bit(8'h55, k)) begin errors++; $display("FAIL single_tx k=%0d got %b exp %b", k, o_tx, exp_bit(8'h55, k)); end
      tick();
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", o_busy); end
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL single_tx_idle got %b exp 1", o_tx); end
  endtask

  task automatic test_back_to_back();
    i_valid = 1'b1; i_data = 8'hA3;
    tick();
    i_data = 8'h0F;
    tick();
    i_valid = 1'b0;
    checks++; if (o_fifo_count !== 4'd1) begin errors++; $display("FAIL b2b_count_start got %0d exp 1", o_fifo_count); end
    for (int k = 0; k < 80; k++) begin
      logic e;
      e = k < 40 ? exp_bit(8'hA3, k) : exp_bit(8'h0F, k - 40);
      checks++; if (o_tx !== e) begin errors++; $display("FAIL b2b_tx k=%0d got %b exp %b", k, o_tx, e); end
      if (k == 40) begin
        checks++; if (o_fifo_count !== 4'd0) begin errors++; $display("FAIL b2b_count_second got %0d exp 0", o_fifo_count); end
      end
      if (k == 39 || k == 79) begin
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d got %b exp 1", k, o_busy); end
      end
      tick();
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", o_busy); end
  endtask

  task automatic test_full();
    i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_data = 8'h10 + 8'(i);
      tick();
    end
    checks++; if (o_fifo_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", o_fifo_count); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", o_ready); end
    i_data = 8'hEE;
    for (int k = 8; k < 40; k++) begin
      checks++; if (o_tx !== exp_bit(8'h10, k)) begin errors++; $display("FAIL full_first_tx k=%0d got %b exp %b", k, o_tx, exp_bit(8'h10, k)); end
      if (k == 39) begin
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pop_edge got %b exp 0", o_ready); end
      end
      tick();
    end
    i_valid = 1'b0;
    checks++; if (o_fifo_count !== 4'd7) begin errors++; $display("FAIL full_pop_edge_count got %0d exp 7", o_fifo_count); end
    for (int f = 1; f <= 8; f++) begin
      for (int k = 0; k < 40; k++) begin
        checks++; if (o_tx !== exp_bit(8'h10 + 8'(f), k)) begin errors++; $display("FAIL full_seq_tx f=%0d k=%0d got %b exp %b", f, k, o_tx, exp_bit(8'h10 + 8'(f), k)); end
        tick();
      end
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b exp 0", o_busy); end
    checks++; if (o_fifo_count !== 4'd0) begin errors++; $display("FAIL full_count_end got %0d exp 0", o_fifo_count); end
  endtask

  task automatic test_reset_mid_frame();
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data = 8'h81 + 8'(i);
      tick();
    end
    i_valid = 1'b0;
    checks++; if (o_fifo_count !== 4'd3) begin errors++; $display("FAIL midrst_count_before got %0d exp 3", o_fifo_count); end
    repeat (8) tick();
    i_reset = 1'b1; i_valid = 1'b1; i_data = 8'h99;
    tick();
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", o_tx); end
    checks++; if (o_fifo_count !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", o_fifo_count); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", o_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", o_ready); end
    i_reset = 1'b0; i_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL midrst_quiet_tx k=%0d got %b exp 1", k, o_tx); end
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] db, e;
    int acc = 0, frames = 0, ds = -1;
    for (int cyc = 0; cyc < 20000 && (acc < 200 || q.size() != 0 || ds >= 0 || o_busy); cyc++) begin
      if (ds < 0 && o_tx == 1'b0) ds = 0;
      if (ds >= 0) begin
        if (ds >= 6 && ds <= 34 && ds % 4 == 2) db[(ds-6)/4] = o_tx;
        if (ds == 38) begin
          checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL rand_stop frame=%0d got %b exp 1", frames, o_tx); end
          e = q.size() != 0 ? q.pop_front() : 8'hxx;
          checks++; if (db !== e) begin errors++; $display("FAIL rand_byte frame=%0d got %02h exp %02h", frames, db, e); end
          frames++;
          ds = -1;
        end else ds++;
      end
      checks++; if (o_fifo_count > 4'd8) begin errors++; $display("FAIL rand_count_bound got %0d exp <=8", o_fifo_count); end
      i_valid = acc < 200 && $urandom_range(0, 3) != 0;
      i_data = 8'($urandom);
      if (i_valid && o_ready) begin q.push_back(i_data); acc++; end
      tick();
    end
    i_valid = 1'b0;
    checks++; if (frames !== 200) begin errors++; $display("FAIL rand_frames got %0d exp 200", frames); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand_leftover got %0d exp 0", q.size()); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rand_busy_end got %b exp 0", o_busy); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16; clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8; byte FIFO depth, power of two, legal range 2..64.
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_data  input  8  byte from SoC UART data output.
REQ-006 SHALL have port i_valid  input  1  i_data valid this cycle.
REQ-007 SHALL have port o_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port o_tx  output  1  serial line, 8N1, idle high.
REQ-009 SHALL have port o_busy  output  1  FIFO non-empty or frame in progress.
REQ-010 SHALL have port o_fifo_count  output  clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the frame being shifted.

Function
REQ-011 SHALL accept a byte into the FIFO on a rising edge where i_valid=1 and o_ready=1; i_data SHALL be ignored otherwise.
REQ-012 SHALL drive o_ready = (o_fifo_count < FIFO_DEPTH), combinationally from registered count; at full, a write SHALL be rejected even if a pop occurs the same cycle.
REQ-013 SHALL, on a same-edge accepted write and pop, leave o_fifo_count unchanged and preserve FIFO order.
REQ-014 SHALL use wrap-around read/write pointers modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or underflow below 0.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: o_tx=1; if o_fifo_count>0, SHALL pop the head byte into an 8-bit shift register, clear the baud counter, and go to START on the same edge.
REQ-017 START: o_tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-018 DATA: o_tx = shift register bit 0 (LSB first); each bit held exactly CLKS_PER_BIT cycles; shift right after each bit; after bit 7, go to STOP.
REQ-019 STOP: o_tx=1 for exactly CLKS_PER_BIT cycles; at end, if FIFO non-empty, SHALL pop and go directly to START (no idle cycle), else go to IDLE.
REQ-020 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL have no gap.
REQ-021 Latency: for a write accepted on edge N into an empty FIFO with FSM in IDLE, count=1 after edge N, pop on edge N+1, o_tx low after edge N+1.
REQ-022 o_tx SHALL be registered (glitch-free).
REQ-023 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit transition SHALL occur on the edge where counter = CLKS_PER_BIT-1.
REQ-024 o_busy SHALL be 1 whenever state != IDLE or o_fifo_count != 0.

Reset
REQ-025 On i_reset=1 at a rising edge: state=IDLE, o_tx=1, o_fifo_count=0, pointers=0, baud counter=0, o_busy=0, o_ready=1.
REQ-026 Reset mid-frame SHALL abort the frame; o_tx SHALL be 1 after that edge; queued bytes SHALL be discarded.
REQ-027 Writes presented while i_reset=1 SHALL be ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-028 Single byte 0x55 written to idle block -> o_tx after pop: 4 cycles 0, then 1,0,1,0,1,0,1,0 (4 cycles each), 4 cycles 1; o_busy low after 40 cycles.
REQ-029 Burst 0xA3,0x0F back-to-back -> two 40-cycle frames with no idle gap; o_busy drops on the edge ending the second stop bit.
REQ-030 Ten consecutive writes with FSM stalled in first frame -> first byte popped, next 8 queued, o_ready=0 at count=8, tenth write rejected; transmitted sequence excludes rejected byte.
REQ-031 At count=8, write asserted on the stop-bit-end pop edge -> write rejected, count becomes 7.
REQ-032 Reset asserted mid-DATA with 3 bytes queued -> next cycle o_tx=1, count=0, o_busy=0, o_ready=1; no further frames.
REQ-033 Random valid/ready traffic of 200 bytes -> serial decoder reproduces exact accepted byte stream in order; count never exceeds 8.
